// File: rtl/btn_debounce_if.sv
// Button conditioner bus: raw inputs towards the debouncer,
// clean levels and pulses back to user logic.
interface btn_debounce_if #(
  parameter int WIDTH = 5
);
  logic [WIDTH-1:0] btn_in;
  logic [WIDTH-1:0] btn_level;
  logic [WIDTH-1:0] btn_rise;
  logic [WIDTH-1:0] btn_fall;
  logic [WIDTH-1:0] btn_repeat;

  modport master (
    output btn_in,
    input  btn_level,
    input  btn_rise,
    input  btn_fall,
    input  btn_repeat
  );

  modport slave (
    input  btn_in,
    output btn_level,
    output btn_rise,
    output btn_fall,
    output btn_repeat
  );
endinterface

// File: rtl/btn_debounce.sv
// Per-channel sync + debounce FSM with level/rise/fall outputs.
// Optional auto-repeat on long hold: define BTN_HOLD_REPEAT_EN.
module btn_debounce #(
  parameter int WIDTH           = 5,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int CNT_W           = 20,
  parameter int HOLD_CYCLES     = 50000000,
  parameter int REPEAT_CYCLES   = 10000000
) (
  input logic         clk,
  input logic         rst_n,
  btn_debounce_if.slave bus
);

  typedef enum logic [1:0] {
    LOW       = 2'd0,
    LOW_PEND  = 2'd1,
    HIGH      = 2'd2,
    HIGH_PEND = 2'd3
  } st_t;

  localparam logic [CNT_W-1:0] LAST =
    CNT_W'(DEBOUNCE_CYCLES - 1);

  if (DEBOUNCE_CYCLES < 2 ||
      DEBOUNCE_CYCLES > (2 ** CNT_W) ||
      HOLD_CYCLES < 1 ||
      REPEAT_CYCLES < 1) begin : g_bad_cfg
    $error("btn_debounce: bad parameters");
  end

  logic [WIDTH-1:0] s1;
  logic [WIDTH-1:0] s2;
  st_t              st_q  [WIDTH];
  st_t              st_d  [WIDTH];
  logic [CNT_W-1:0] cnt_q [WIDTH];
  logic [CNT_W-1:0] cnt_d [WIDTH];
  logic [WIDTH-1:0] level_d;
  logic [WIDTH-1:0] level_q;
  logic [WIDTH-1:0] rise_q;
  logic [WIDTH-1:0] fall_q;
  logic [WIDTH-1:0] rep_d;
  logic [WIDTH-1:0] rep_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= bus.btn_in;
      s2 <= s1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < WIDTH; i++) begin
        st_q[i]  <= LOW;
        cnt_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        st_q[i]  <= st_d[i];
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  // cnt holds the run length of the pending level minus one
  always_comb begin
    for (int i = 0; i < WIDTH; i++) begin
      st_d[i]  = st_q[i];
      cnt_d[i] = cnt_q[i];
      unique case (st_q[i])
        LOW: begin
          if (s2[i]) begin
            st_d[i]  = LOW_PEND;
            cnt_d[i] = CNT_W'(1);
          end
        end
        LOW_PEND: begin
          if (!s2[i]) begin
            st_d[i]  = LOW;
            cnt_d[i] = '0;
          end else if (cnt_q[i] == LAST) begin
            st_d[i]  = HIGH;
            cnt_d[i] = '0;
          end else begin
            cnt_d[i] = cnt_q[i] + CNT_W'(1);
          end
        end
        HIGH: begin
          if (!s2[i]) begin
            st_d[i]  = HIGH_PEND;
            cnt_d[i] = CNT_W'(1);
          end
        end
        HIGH_PEND: begin
          if (s2[i]) begin
            st_d[i]  = HIGH;
            cnt_d[i] = '0;
          end else if (cnt_q[i] == LAST) begin
            st_d[i]  = LOW;
            cnt_d[i] = '0;
          end else begin
            cnt_d[i] = cnt_q[i] + CNT_W'(1);
          end
        end
        default: begin
          st_d[i]  = LOW;
          cnt_d[i] = '0;
        end
      endcase
    end
  end

  always_comb begin
    level_d = '0;
    for (int i = 0; i < WIDTH; i++) begin
      level_d[i] = (st_q[i] == HIGH) ||
                   (st_q[i] == HIGH_PEND);
    end
  end

`ifdef BTN_HOLD_REPEAT_EN
  localparam int HMAX =
    (HOLD_CYCLES > REPEAT_CYCLES) ?
    HOLD_CYCLES : REPEAT_CYCLES;
  localparam int HW = $clog2(HMAX + 1);
  localparam logic [HW-1:0] HOLD_T = HW'(HOLD_CYCLES);
  localparam logic [HW-1:0] RPT_T  = HW'(REPEAT_CYCLES);

  logic [HW-1:0]    hold_q [WIDTH];
  logic [HW-1:0]    hold_d [WIDTH];
  logic [WIDTH-1:0] mode_q;
  logic [WIDTH-1:0] mode_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < WIDTH; i++) begin
        hold_q[i] <= '0;
      end
      mode_q <= '0;
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        hold_q[i] <= hold_d[i];
      end
      mode_q <= mode_d;
    end
  end

  // hold_q counts cycles since the last pulse (or since acceptance);
  // mode_q selects the first-hold or the repeat period
  always_comb begin
    rep_d  = '0;
    mode_d = mode_q;
    for (int i = 0; i < WIDTH; i++) begin
      hold_d[i] = hold_q[i];
      if (level_d[i]) begin
        rep_d[i] = hold_q[i] == (mode_q[i] ? RPT_T : HOLD_T);
        if (st_d[i] == LOW) begin
          hold_d[i] = '0;
          mode_d[i] = 1'b0;
        end else if (rep_d[i]) begin
          hold_d[i] = HW'(1);
          mode_d[i] = 1'b1;
        end else begin
          hold_d[i] = hold_q[i] + HW'(1);
        end
      end
    end
  end
`else
  assign rep_d = '0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level_q <= '0;
      rise_q  <= '0;
      fall_q  <= '0;
      rep_q   <= '0;
    end else begin
      level_q <= level_d;
      rise_q  <= level_d & ~level_q;
      fall_q  <= ~level_d & level_q;
      rep_q   <= rep_d;
    end
  end

  assign bus.btn_level  = level_q;
  assign bus.btn_rise   = rise_q;
  assign bus.btn_fall   = fall_q;
  assign bus.btn_repeat = rep_q;

endmodule
